// File: rtl/z80bd_iord.sv
// Z80BD read-side I/O responder: mapper page read-back, status port and 16550 interrupt path.
// Define Z80BD_IM2_VECTOR_EN to drive INT_VECTOR during interrupt acknowledge (IM2).
module z80bd_iord #(
    parameter logic [7:0] MMAP_BASE  = 8'h10,
    parameter logic [7:0] STAT_PORT  = 8'h14,
    parameter logic [7:0] INT_VECTOR = 8'hFE
) (
    input  logic       CLK_24MHz,
    input  logic       RES,
    input  logic       IORQ,
    input  logic       RD,
    input  logic       M1,
    input  logic [7:0] A,
    input  logic [7:0] PAGE0,
    input  logic [7:0] PAGE1,
    input  logic [7:0] PAGE2,
    input  logic [7:0] PAGE3,
    input  logic       U_INT,
    output logic [7:0] D_OUT,
    output logic       D_OE,
    output logic       INT
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DRIVE   = 2'b01,
        WAITEND = 2'b10
    } state_t;

    state_t      state, state_nx;
    logic        iorq_m, iorq_s, rd_m, rd_s, m1_m, m1_s;
    logic        uint_m, uint_s, uint_h;
    logic [1:0]  sync_ok;
    logic        armed;
    logic        int_pending;
    logic        rd_cyc, ack_cyc, idle_bus, uint_rise;
    logic [7:0]  page_off;
    logic        map_hit, stat_hit;
    logic [7:0]  rd_data;
    logic [7:0]  d_out_nx;
    logic        ack_take;

    always_ff @(negedge CLK_24MHz or negedge RES) begin
        if (!RES) begin
            iorq_m  <= 1'b1;
            iorq_s  <= 1'b1;
            rd_m    <= 1'b1;
            rd_s    <= 1'b1;
            m1_m    <= 1'b1;
            m1_s    <= 1'b1;
            uint_m  <= 1'b0;
            uint_s  <= 1'b0;
            uint_h  <= 1'b0;
            sync_ok <= '0;
        end else begin
            iorq_m  <= IORQ;
            iorq_s  <= iorq_m;
            rd_m    <= RD;
            rd_s    <= rd_m;
            m1_m    <= M1;
            m1_s    <= m1_m;
            uint_m  <= U_INT;
            uint_s  <= uint_m;
            uint_h  <= uint_s;
            sync_ok <= {sync_ok[0], 1'b1};
        end
    end

    assign rd_cyc    = !iorq_s && !rd_s && m1_s;
    assign ack_cyc   = !iorq_s && !m1_s;
    assign idle_bus  = iorq_s;
    assign uint_rise = uint_s && !uint_h;

    // Sync flops reset high, so IORQ only counts as seen high once they hold real pin samples;
    // this keeps a cycle already in progress across reset from being answered.
    always_ff @(negedge CLK_24MHz or negedge RES) begin
        if (!RES) begin
            armed <= 1'b0;
        end else if (sync_ok[1] && idle_bus) begin
            armed <= 1'b1;
        end
    end

    // Modulo-256 offset so the four mapper ports may wrap past FFh.
    assign page_off = A - MMAP_BASE;
    assign map_hit  = (page_off[7:2] == 6'd0);
    assign stat_hit = (A == STAT_PORT);

    always_comb begin
        rd_data = {uint_s, int_pending, 4'b0000, state};
        if (map_hit) begin
            case (page_off[1:0])
                2'd0:    rd_data = PAGE0;
                2'd1:    rd_data = PAGE1;
                2'd2:    rd_data = PAGE2;
                default: rd_data = PAGE3;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        d_out_nx = D_OUT;
        ack_take = 1'b0;
        case (state)
            IDLE: begin
                if (armed) begin
                    if (rd_cyc) begin
                        if (map_hit || stat_hit) begin
                            d_out_nx = rd_data;
                            state_nx = DRIVE;
                        end else begin
                            state_nx = WAITEND;
                        end
                    end else if (ack_cyc) begin
                        ack_take = 1'b1;
`ifdef Z80BD_IM2_VECTOR_EN
                        d_out_nx = INT_VECTOR;
                        state_nx = DRIVE;
`else
                        state_nx = WAITEND;
`endif
                    end
                end
            end
            DRIVE: begin
                if (idle_bus) state_nx = IDLE;
            end
            WAITEND: begin
                if (idle_bus) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifndef Z80BD_IM2_VECTOR_EN
    logic unused_vector;
    assign unused_vector = ^INT_VECTOR;
`endif

    always_ff @(negedge CLK_24MHz or negedge RES) begin
        if (!RES) begin
            state <= IDLE;
            D_OUT <= '0;
            D_OE  <= 1'b0;
        end else begin
            state <= state_nx;
            D_OUT <= d_out_nx;
            D_OE  <= (state_nx == DRIVE);
        end
    end

    // A new request on the acknowledge edge must not be lost, so set has priority.
    always_ff @(negedge CLK_24MHz or negedge RES) begin
        if (!RES) begin
            int_pending <= 1'b0;
            INT         <= 1'b1;
        end else begin
            if (uint_rise) begin
                int_pending <= 1'b1;
            end else if (ack_take) begin
                int_pending <= 1'b0;
            end
            INT <= ~int_pending;
        end
    end

endmodule

// File: tb/tb_z80bd_iord.sv
// Directed bench for z80bd_iord: read-back, status, interrupt ack, wrap and reset behaviour.
module tb_z80bd_iord;

    logic       clk;
    logic       res;
    logic       iorq, rd, m1, u_int;
    logic [7:0] a;
    logic [7:0] page0, page1, page2, page3;
    logic [7:0] d_out, d2_out;
    logic       d_oe, d2_oe;
    logic       int_n, d2_int;

    int checks = 0;
    int errors = 0;

    z80bd_iord dut (
        .CLK_24MHz(clk), .RES(res), .IORQ(iorq), .RD(rd), .M1(m1), .A(a),
        .PAGE0(page0), .PAGE1(page1), .PAGE2(page2), .PAGE3(page3),
        .U_INT(u_int), .D_OUT(d_out), .D_OE(d_oe), .INT(int_n)
    );

    z80bd_iord #(.MMAP_BASE(8'hFE)) dut_wrap (
        .CLK_24MHz(clk), .RES(res), .IORQ(iorq), .RD(rd), .M1(m1), .A(a),
        .PAGE0(page0), .PAGE1(page1), .PAGE2(page2), .PAGE3(page3),
        .U_INT(u_int), .D_OUT(d2_out), .D_OE(d2_oe), .INT(d2_int)
    );

    initial clk = 1'b0;
    always #21 clk = ~clk;

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    initial begin
        res = 1'b0; iorq = 1'b1; rd = 1'b1; m1 = 1'b1; u_int = 1'b0; a = 8'h00;
        page0 = 8'h01; page1 = 8'h77; page2 = 8'h5A; page3 = 8'hC3;

        tick(3);
        chk("rst_doe", {7'd0, d_oe}, 8'h00);
        chk("rst_int", {7'd0, int_n}, 8'h01);
        chk("rst_dout", d_out, 8'h00);
        res = 1'b1;
        tick(5);

        // Page2 read at 12h, data held while PAGE2 changes
        a = 8'h12; iorq = 1'b0; rd = 1'b0;
        tick(2);
        chk("p2_doe_edge2", {7'd0, d_oe}, 8'h00);
        tick(1);
        chk("p2_doe_edge3", {7'd0, d_oe}, 8'h01);
        chk("p2_dout", d_out, 8'h5A);
        page2 = 8'h33;
        tick(3);
        chk("p2_hold", d_out, 8'h5A);
        chk("p2_doe_hold", {7'd0, d_oe}, 8'h01);
        iorq = 1'b1; rd = 1'b1;
        tick(2);
        chk("p2_rel_edge2", {7'd0, d_oe}, 8'h01);
        tick(1);
        chk("p2_rel_edge3", {7'd0, d_oe}, 8'h00);
        tick(2);

        // Unmapped port 20h never drives
        a = 8'h20; iorq = 1'b0; rd = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("nomatch_doe", {7'd0, d_oe}, 8'h00);
        end
        iorq = 1'b1; rd = 1'b1;
        tick(4);
        a = 8'h10; iorq = 1'b0; rd = 1'b0;
        tick(3);
        chk("p0_doe", {7'd0, d_oe}, 8'h01);
        chk("p0_dout", d_out, 8'h01);
        iorq = 1'b1; rd = 1'b1;
        tick(4);
        chk("p0_rel", {7'd0, d_oe}, 8'h00);

        // Interrupt request, status read, acknowledge
        u_int = 1'b1;
        tick(3);
        chk("int_edge3", {7'd0, int_n}, 8'h01);
        tick(1);
        chk("int_edge4", {7'd0, int_n}, 8'h00);
        a = 8'h14; iorq = 1'b0; rd = 1'b0;
        tick(3);
        chk("stat_doe", {7'd0, d_oe}, 8'h01);
        chk("stat_dout", d_out, 8'hC0);
        iorq = 1'b1; rd = 1'b1;
        tick(4);
        chk("stat_int_kept", {7'd0, int_n}, 8'h00);
        m1 = 1'b0; iorq = 1'b0;
        tick(3);
`ifdef Z80BD_IM2_VECTOR_EN
        chk("ack_doe", {7'd0, d_oe}, 8'h01);
        chk("ack_vec", d_out, 8'hFE);
`else
        chk("ack_doe", {7'd0, d_oe}, 8'h00);
`endif
        chk("ack_int_edge3", {7'd0, int_n}, 8'h00);
        tick(1);
        chk("ack_int_clr", {7'd0, int_n}, 8'h01);
        m1 = 1'b1; iorq = 1'b1;
        tick(4);
        chk("ack_rel", {7'd0, d_oe}, 8'h00);

        // Rising U_INT on the acknowledge edge keeps the request pending
        u_int = 1'b0;
        tick(4);
        u_int = 1'b1;
        tick(4);
        chk("int2_low", {7'd0, int_n}, 8'h00);
        u_int = 1'b0;
        tick(4);
        u_int = 1'b1; m1 = 1'b0; iorq = 1'b0;
        tick(4);
        chk("setwins_int", {7'd0, int_n}, 8'h00);
        m1 = 1'b1; iorq = 1'b1;
        tick(4);
        chk("setwins_int_after", {7'd0, int_n}, 8'h00);
        m1 = 1'b0; iorq = 1'b0;
        tick(4);
        chk("ack2_int_clr", {7'd0, int_n}, 8'h01);
        m1 = 1'b1; iorq = 1'b1;
        tick(4);

        // Mapper window wrapping past FFh (base FEh: page3 at 01h)
        a = 8'h01; iorq = 1'b0; rd = 1'b0;
        tick(3);
        chk("wrap_doe", {7'd0, d2_oe}, 8'h01);
        chk("wrap_dout", d2_out, 8'hC3);
        chk("wrap_main_quiet", {7'd0, d_oe}, 8'h00);
        iorq = 1'b1; rd = 1'b1;
        tick(4);
        a = 8'h02; iorq = 1'b0; rd = 1'b0;
        tick(4);
        chk("wrap_past_end", {7'd0, d2_oe}, 8'h00);
        iorq = 1'b1; rd = 1'b1;
        tick(4);

        // Reset in the middle of a drive
        a = 8'h11; iorq = 1'b0; rd = 1'b0;
        tick(3);
        chk("p1_doe", {7'd0, d_oe}, 8'h01);
        chk("p1_dout", d_out, 8'h77);
        #5 res = 1'b0;
        #1;
        chk("rst_mid_doe", {7'd0, d_oe}, 8'h00);
        chk("rst_mid_dout", d_out, 8'h00);
        tick(2);
        res = 1'b1;
        tick(8);
        chk("no_rearm", {7'd0, d_oe}, 8'h00);
        iorq = 1'b1; rd = 1'b1;
        tick(4);
        iorq = 1'b0; rd = 1'b0;
        tick(3);
        chk("rearm_doe", {7'd0, d_oe}, 8'h01);
        chk("rearm_dout", d_out, 8'h77);
        iorq = 1'b1; rd = 1'b1;
        tick(4);
        chk("final_doe", {7'd0, d_oe}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z80bd_iord.md
# z80bd_iord

Read-side I/O responder for the Z80BD CPLD. It answers Z80 `IN` cycles on the memory-mapper ports, so the CPU can read back the four page registers that the mapper captures on `OUT`. It also answers a status port and runs the 16550 interrupt request/acknowledge path, including an optional IM2 vector. It sits beside the mapper and returns read data through a `D_OUT`/`D_OE` pair; the top level drives the `D` tri-state from that pair.

## Interface
Parameters:
- `MMAP_BASE`, 8'h10: low I/O address of page0. Page0..page3 are read at `MMAP_BASE`..`MMAP_BASE+3`.
- `STAT_PORT`, 8'h14: status port address.
- `INT_VECTOR`, 8'hFE: byte driven during interrupt acknowledge (IM2 only).

Ports:
- `CLK_24MHz` in 1: the only clock. All flops update on its falling edge.
- `RES` in 1: asynchronous, active-low reset.
- `IORQ` in 1: Z80 IORQ, active low, asynchronous to `CLK_24MHz`.
- `RD` in 1: Z80 RD, active low, asynchronous.
- `M1` in 1: Z80 M1, active low, asynchronous.
- `A` in 8: Z80 A[7:0].
- `PAGE0`..`PAGE3` in 8 each: mapper page registers.
- `U_INT` in 1: 16550 INTR, active high, asynchronous.
- `D_OUT` out 8: read data.
- `D_OE` out 1: high means the top level drives `D` with `D_OUT`.
- `INT` out 1: Z80 INT, active low.

## Operation
**Synchronisers**
- `IORQ`, `RD` and `M1` each pass through a 2-flop synchroniser; their sync flops reset to 1.
- `U_INT` passes through a 2-flop synchroniser plus one history flop; these reset to 0.

**Cycle classes** (evaluated on synchronised signals)
- rd_cyc = !iorq_s & !rd_s & m1_s.
- ack_cyc = !iorq_s & !m1_s.
- idle_bus = iorq_s.

**State machine:** IDLE, DRIVE, WAITEND.
- IDLE, on rd_cyc:
  - `A` matches a mapper port or `STAT_PORT`: latch `D_OUT`, go to DRIVE.
  - No match: go to WAITEND. `D_OE` stays 0.
- IDLE, on ack_cyc:
  - With IM2 enabled: `D_OUT` <= `INT_VECTOR`, go to DRIVE.
  - Otherwise: go to WAITEND.
- DRIVE: `D_OE` = 1. When idle_bus, clear `D_OE` and go to IDLE.
- WAITEND: go to IDLE when idle_bus.
- Exactly one response is made per bus cycle. The block only re-arms after `IORQ` has been seen high.

**Read data**
- Mapper ports: `PAGEn` is sampled once at the IDLE->DRIVE transition and held for the whole cycle.
- Status byte: {`U_INT` synced, int_pending, 4'b0, state[1:0]}.
- Reading the status port has no side effects.

**Interrupt**
- int_pending is set on a rising edge of synchronised `U_INT`.
- int_pending is cleared at the IDLE transition that is taken on ack_cyc.
- A rising edge and an ack on the same edge: set wins, and int_pending stays 1.
- `INT` = ~int_pending, registered.

**Reset values**
- `D_OUT` = 0, `D_OE` = 0, `INT` = 1, state = IDLE, int_pending = 0.
- Reset asserted mid-DRIVE: `D_OE` drops immediately (asynchronously).

**Width:** port match is an 8-bit compare. `MMAP_BASE+3` wraps modulo 256.

## Timing
- Response latency: `D_OE` rises on the 3rd falling edge of `CLK_24MHz` after `IORQ` and `RD` are both low at the pins (2 sync edges + 1 FSM edge). That is ≤125 ns, well inside the Z80 I/O read window at `CLK` = 24 MHz/16.
- Release latency: `D_OE` falls on the 3rd falling edge after `IORQ` rises (≤125 ns). This is before the next bus cycle can begin.
- `U_INT` to `INT` low: 4 falling edges (2 sync, 1 edge detect, 1 output register).
- `A` must be stable while `IORQ` is low; the Z80 guarantees this. Because `A` is sampled in the same edge as detection, it needs no synchroniser.
- Glitches shorter than one `CLK_24MHz` period on `IORQ` may be missed. That is acceptable.

## Configuration
- `Z80BD_IM2_VECTOR_EN` defined: on an acknowledge cycle, DRIVE outputs `INT_VECTOR`.
- Undefined: acknowledge cycles still clear int_pending, but `D_OE` stays 0 (IM1 operation, bus floats to FFh). The DRIVE path for ack is not synthesised.

## Test plan
- Reset, then check outputs: `D_OE`=0, `INT`=1, `D_OUT`=00h.
- `PAGE2`=5Ah, `IN` from port 12h -> `D_OE`=1 by the 3rd falling edge and `D_OUT`=5Ah. Change `PAGE2` to 33h while `RD` is still low -> `D_OUT` stays 5Ah. `IORQ` high -> `D_OE`=0 within 3 edges.
- `IN` from port 20h -> `D_OE` stays 0 throughout. A following `IN` from 10h with `PAGE0`=01h -> returns 01h.
- `U_INT` rises -> `INT`=0 after 4 edges. Status `IN` from 14h -> C0h | state, and `INT` stays 0. `M1`+`IORQ` ack with macro defined -> `D_OUT`=FEh, `D_OE`=1, then `INT`=1.
- Same ack with macro undefined -> `D_OE`=0 and `INT`=1. Second case: a `U_INT` rising edge on the ack edge -> `INT` remains 0.
- `RES` pulsed low mid-DRIVE -> `D_OE`=0 immediately. After release, the still-low `IORQ` is not answered until `IORQ` goes high and low again.
